// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, memory
// access size encoding, the prefetch queue entry layout and the default
// reset fetch address.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0001_0000;

    // Access size encoding carried on the memory port.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    // FETCH issues reads; DRAIN waits out a read orphaned by a redirect.
    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    // One prefetched instruction and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential successor of a word-aligned fetch address (wraps mod 2^32).
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/tinymemif.sv
// Simple single-port memory interface.
//   master: drives rd_addr/rd_enable/rd_size and the write side,
//           receives rd_data and busy.
//   slave : the memory side.
// A read completes in the cycle where rd_enable=1 and busy=0; rd_data is
// only meaningful in that cycle.
interface tinymemif;
    import fetch_unit_pkg::*;

    logic [XLEN-1:0] rd_addr;
    logic            rd_enable;
    mem_size_t       rd_size;
    logic [XLEN-1:0] rd_data;
    logic            busy;
    logic [XLEN-1:0] wr_addr;
    logic            wr_enable;
    logic [XLEN-1:0] wr_data;

    modport master (
        output rd_addr, rd_enable, rd_size, wr_addr, wr_enable, wr_data,
        input  rd_data, busy
    );

    modport slave (
        input  rd_addr, rd_enable, rd_size, wr_addr, wr_enable, wr_data,
        output rd_data, busy
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of prefetched {pc, instr} entries.
//   clk_i, reset_ni : clock, synchronous active-low reset
//   push, wdata     : enqueue one entry (caller guarantees not full)
//   pop             : dequeue the head (caller guarantees not empty)
//   flush           : empty the queue, overrides push/pop
//   rdata           : head entry (undefined when count=0)
//   count           : number of valid entries, 0..DEPTH
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    // Storage array; not reset, contents qualified by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!reset_ni || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction prefetch unit: streams sequential words from memory into a
// small queue, presents the head with a valid/ready handshake and restarts
// on redirect.
//   clk_i, reset_ni      : clock, synchronous active-low reset
//   memif                : instruction read port (write side tied off)
//   redirect_i/_pc_i     : flush and restart fetch at a new word address
//   valid_o/ready_i      : head-of-queue handshake
//   instr_o, pc_o        : head instruction and its address (0 when empty)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 4
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    tinymemif.master     memif,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [31:0]  instr_o,
    output logic [31:0]  pc_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   drain_pc_q, drain_pc_d;
    logic          rd_en_c;
    logic [31:0]   rd_addr_c;
    logic          push, pop, flush;
    logic [CW-1:0] count;
    logic          has_data, not_full;
    fetch_entry_t  head, entry_in;
    logic [31:0]   redirect_target;
    logic [1:0]    unused_redirect_lsb;

    assign redirect_target     = {redirect_pc_i[31:2], 2'b00};
    assign unused_redirect_lsb = redirect_pc_i[1:0];

    assign has_data = (count != '0);
    assign not_full = (count < CW'(DEPTH));
    assign entry_in = '{pc: fetch_pc_q, instr: memif.rd_data};

    // State and fetch address registers.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            drain_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drain_pc_q <= drain_pc_d;
        end
    end

    // Next-state, read request and queue control.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drain_pc_d = drain_pc_q;
        rd_en_c    = 1'b0;
        rd_addr_c  = fetch_pc_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;

        case (state_q)
            FETCH: begin
                rd_en_c = not_full;
                if (redirect_i) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_target;
                    // A stalled read cannot be withdrawn; park its address.
                    if (not_full && memif.busy) begin
                        state_d    = DRAIN;
                        drain_pc_d = fetch_pc_q;
                    end
                end else begin
                    pop = has_data && ready_i;
                    if (not_full && !memif.busy) begin
                        push       = 1'b1;
                        fetch_pc_d = next_pc(fetch_pc_q);
                    end
                end
            end
            DRAIN: begin
                // Hold the orphaned request until memory finishes; drop its data.
                rd_en_c   = 1'b1;
                rd_addr_c = drain_pc_q;
                if (!memif.busy) begin
                    state_d = FETCH;
                end
                if (redirect_i) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_target;
                end else begin
                    pop = has_data && ready_i;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Reset abandons any read in progress.
        if (!reset_ni) begin
            rd_en_c = 1'b0;
            push    = 1'b0;
            pop     = 1'b0;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wdata    (entry_in),
        .rdata    (head),
        .count    (count)
    );

    assign memif.rd_enable = rd_en_c;
    assign memif.rd_addr   = rd_addr_c;
    assign memif.rd_size   = SIZE_WORD;
    assign memif.wr_enable = 1'b0;
    assign memif.wr_addr   = '0;
    assign memif.wr_data   = '0;

    assign valid_o = reset_ni && has_data;
    assign instr_o = valid_o ? head.instr : '0;
    assign pc_o    = valid_o ? head.pc    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomised phase, checked against a reference model and scoreboard.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        busy;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    int n_vec = 0;
    int n_err = 0;

    tinymemif mem ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign mem.busy    = busy;
    assign mem.rd_data = (mem.rd_enable && !busy) ? mem_word(mem.rd_addr) : 32'hDEAD_BEEF;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .memif         (mem),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    fetch_entry_t sb[$];
    logic [31:0]  m_pc;
    logic         m_drain;
    logic [31:0]  m_drain_addr;
    logic         prev_pend;
    logic [31:0]  prev_addr;
    int           comp_cnt = 0;

    // Evaluated on the falling edge: inputs are settled and describe what
    // the DUT will do at the next rising edge.
    task automatic monitor_cycle();
        fetch_entry_t e;
        logic         comp;
        if (!reset_ni) begin
            check("rst_rd_en", 32'(mem.rd_enable), 32'd0);
            check("rst_valid", 32'(valid_o), 32'd0);
            check("rst_instr", instr_o, 32'd0);
            check("rst_pc", pc_o, 32'd0);
            sb.delete();
            m_pc      = RST_PC;
            m_drain   = 1'b0;
            prev_pend = 1'b0;
            return;
        end
        if (prev_pend) begin
            check("hold_en", 32'(mem.rd_enable), 32'd1);
            check("hold_addr", mem.rd_addr, prev_addr);
        end
        check("valid", 32'(valid_o), 32'(sb.size() != 0));
        if (!valid_o) begin
            check("idle_instr", instr_o, 32'd0);
            check("idle_pc", pc_o, 32'd0);
        end
        comp = mem.rd_enable && !busy;
        if (comp) comp_cnt++;
        if (m_drain) begin
            check("drain_en", 32'(mem.rd_enable), 32'd1);
            check("drain_addr", mem.rd_addr, m_drain_addr);
            if (comp) m_drain = 1'b0;
            if (redirect_i) m_pc = {redirect_pc_i[31:2], 2'b00};
        end else begin
            check("rd_en", 32'(mem.rd_enable), 32'(sb.size() < DEPTH));
            if (mem.rd_enable) check("rd_addr", mem.rd_addr, m_pc);
            if (redirect_i) begin
                sb.delete();
                if (mem.rd_enable && busy) begin
                    m_drain      = 1'b1;
                    m_drain_addr = m_pc;
                end
                m_pc = {redirect_pc_i[31:2], 2'b00};
            end else begin
                if (valid_o && ready_i && sb.size() != 0) begin
                    e = sb.pop_front();
                    check("head_pc", pc_o, e.pc);
                    check("head_instr", instr_o, e.instr);
                end
                if (comp) begin
                    sb.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        prev_pend = mem.rd_enable && busy;
        prev_addr = mem.rd_addr;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_cycle();
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_ni      = 1'b0;
        busy          = 1'b0;
        ready_i       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        step(3);
        reset_ni = 1'b1;

        // Startup latency and sequential fetch.
        @(negedge clk);
        check("t0_addr", mem.rd_addr, 32'h0001_0000);
        check("t0_valid", 32'(valid_o), 32'd0);
        check("wr_enable", 32'(mem.wr_enable), 32'd0);
        check("wr_addr", mem.wr_addr, 32'd0);
        check("wr_data", mem.wr_data, 32'd0);
        check("rd_size", 32'(mem.rd_size), 32'(SIZE_WORD));
        @(negedge clk);
        check("t1_addr", mem.rd_addr, 32'h0001_0004);
        check("t1_valid", 32'(valid_o), 32'd1);
        check("t1_pc", pc_o, 32'h0001_0000);
        @(negedge clk);
        check("t2_addr", mem.rd_addr, 32'h0001_0008);
        check("t2_pc", pc_o, 32'h0001_0004);
        step(5);

        // Fill the queue with the consumer stalled.
        ready_i       = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = RST_PC;
        step(1);
        redirect_i = 1'b0;
        comp_cnt   = 0;
        step(8);
        check("full_reads", 32'(comp_cnt), 32'd4);
        @(negedge clk);
        check("full_rd_en", 32'(mem.rd_enable), 32'd0);
        check("full_head", pc_o, 32'h0001_0000);
        step(1);
        ready_i = 1'b1;
        @(negedge clk);
        check("resume_en0", 32'(mem.rd_enable), 32'd0);
        @(negedge clk);
        check("resume_en1", 32'(mem.rd_enable), 32'd1);
        check("resume_addr", mem.rd_addr, 32'h0001_0010);

        // Memory stall on the second read after a restart.
        step(1);
        redirect_i    = 1'b1;
        redirect_pc_i = RST_PC;
        step(1);
        redirect_i = 1'b0;
        step(1);
        busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) busy = 1'b0;
            @(negedge clk);
            check("stall_addr", mem.rd_addr, 32'h0001_0004);
            step(1);
        end

        // Redirect while a read is stalled: drain and discard.
        busy = 1'b1;
        step(1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0002_0003;
        step(1);
        redirect_i = 1'b0;
        @(negedge clk);
        check("drain_v0", 32'(valid_o), 32'd0);
        step(1);
        busy = 1'b0;
        @(negedge clk);
        check("drain_v1", 32'(valid_o), 32'd0);
        step(1);
        @(negedge clk);
        check("post_drain_addr", mem.rd_addr, 32'h0002_0000);
        check("post_drain_v", 32'(valid_o), 32'd0);
        step(1);
        @(negedge clk);
        check("post_drain_pc", pc_o, 32'h0002_0000);

        // Redirect coinciding with completion and pop.
        step(3);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0003_0000;
        step(1);
        redirect_i = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(valid_o), 32'd0);
        check("flush_addr", mem.rd_addr, 32'h0003_0000);
        step(1);
        @(negedge clk);
        check("flush_pc", pc_o, 32'h0003_0000);

        // Address wrap-around.
        step(1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step(1);
        redirect_i = 1'b0;
        @(negedge clk);
        check("wrap_addr0", mem.rd_addr, 32'hFFFF_FFFC);
        step(1);
        @(negedge clk);
        check("wrap_pc0", pc_o, 32'hFFFF_FFFC);
        check("wrap_addr1", mem.rd_addr, 32'h0000_0000);
        step(1);
        @(negedge clk);
        check("wrap_pc1", pc_o, 32'h0000_0000);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step(1);
            busy          = ($urandom_range(0, 3) == 0);
            ready_i       = ($urandom_range(0, 9) < 7);
            redirect_i    = ($urandom_range(0, 39) == 0);
            redirect_pc_i = $urandom();
        end

        // Reset in the middle of a stalled read.
        step(1);
        redirect_i = 1'b0;
        busy       = 1'b1;
        step(1);
        reset_ni = 1'b0;
        step(2);
        busy     = 1'b0;
        reset_ni = 1'b1;
        @(negedge clk);
        check("rerst_addr", mem.rd_addr, RST_PC);
        check("rerst_en", 32'(mem.rd_enable), 32'd1);
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
